// File: rtl/alu_wb_arbiter_pkg.sv
// Shared payload types for the ALU commit/writeback path.
package alu_wb_arbiter_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_PREG_W = 6;

  typedef struct packed {
    logic valid;
  } BaseInfoSt;

  typedef struct packed {
    BaseInfoSt               base_info;
    logic                    we;
    logic [ALU_PREG_W-1:0]   pdest;
    logic [ALU_DATA_W-1:0]   wdata;
  } AluCmtSt;

  typedef struct packed {
    logic                    we;
    logic [ALU_PREG_W-1:0]   pdest;
    logic [ALU_DATA_W-1:0]   wdata;
  } AluWbSt;

  // Strip the handshake info to get the buffered writeback payload.
  function automatic AluWbSt cmt_to_wb(input AluCmtSt c);
    AluWbSt w;
    w.we    = c.we;
    w.pdest = c.pdest;
    w.wdata = c.wdata;
    return w;
  endfunction

endpackage

// File: rtl/alu_wb_arbiter_wb_fifo.sv
// Per-pipe synchronous FIFO holding writeback payloads; flush empties it in one edge.
module wb_fifo
  import alu_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  AluWbSt din,
  output logic   full,
  output logic   empty,
  output AluWbSt head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  AluWbSt             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Buffers ALU pipe results per pipe and round-robin arbitrates one per cycle
// onto the regfile write port and the wakeup broadcast.
module alu_wb_arbiter
  import alu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PIPES  = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = ALU_DATA_W,
  parameter int unsigned PREG_W     = ALU_PREG_W
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  flush_i,
  input  AluCmtSt               cmt_i [NUM_PIPES],
  output logic [NUM_PIPES-1:0]  cmt_ready_o,
  output logic                  rf_we_o,
  output logic [PREG_W-1:0]     rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic                  wakeup_valid_o,
  output logic [PREG_W-1:0]     wakeup_pdest_o
);

  localparam int unsigned PTR_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  // Async assert, sync deassert reset.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [NUM_PIPES-1:0] push;
  logic [NUM_PIPES-1:0] pop;
  logic [NUM_PIPES-1:0] full;
  logic [NUM_PIPES-1:0] empty;
  AluWbSt               head [NUM_PIPES];
  AluWbSt               win;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     rr_ptr;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    assign cmt_ready_o[i] = rst_n & ~full[i];
    assign push[i]        = cmt_i[i].base_info.valid & cmt_ready_o[i] & ~flush_i;
    assign pop[i]         = grant_valid & (grant_idx == PTR_W'(i));

    wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (flush_i),
      .din   (cmt_to_wb(cmt_i[i])),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // First non-empty pipe at or after rr_ptr, with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned off = 0; off < NUM_PIPES; off++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + off) % NUM_PIPES;
      if (!grant_valid && !empty[PTR_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign win = head[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      wakeup_valid_o <= 1'b0;
      wakeup_pdest_o <= '0;
      rr_ptr         <= '0;
    end else if (flush_i) begin
      rf_we_o        <= 1'b0;
      wakeup_valid_o <= 1'b0;
    end else begin
      rf_we_o        <= grant_valid & win.we;
      wakeup_valid_o <= grant_valid & win.we;
      if (grant_valid) begin
        rf_waddr_o     <= win.pdest;
        rf_wdata_o     <= win.wdata;
        wakeup_pdest_o <= win.pdest;
        rr_ptr         <= (grant_idx == PTR_W'(NUM_PIPES - 1)) ? '0
                                                               : PTR_W'(grant_idx + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_arbiter.sv
// Directed self-checking bench for alu_wb_arbiter (2 pipes, depth-2 FIFOs).
module tb_alu_wb_arbiter;
  import alu_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        a_rst_n = 1'b0;
  logic        flush_i = 1'b0;
  AluCmtSt     cmt_i [2];
  logic [1:0]  cmt_ready_o;
  logic        rf_we_o;
  logic [5:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        wakeup_valid_o;
  logic [5:0]  wakeup_pdest_o;

  alu_wb_arbiter #(
    .NUM_PIPES  (2),
    .FIFO_DEPTH (2),
    .DATA_W     (32),
    .PREG_W     (6)
  ) dut (
    .clk            (clk),
    .a_rst_n        (a_rst_n),
    .flush_i        (flush_i),
    .cmt_i          (cmt_i),
    .cmt_ready_o    (cmt_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .wakeup_valid_o (wakeup_valid_o),
    .wakeup_pdest_o (wakeup_pdest_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0]  q0 [$];
  logic [5:0]  q1 [$];
  int          wlog [$];
  logic [31:0] wdat [$];
  logic        wwv  [$];
  logic [5:0]  wwp  [$];
  int          wcyc [$];
  bit          rdy0_low;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [5:0] pd);
    return 32'h1000 + {26'd0, pd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [5:0] pd);
    cmt_i[p].base_info.valid = v;
    cmt_i[p].we              = we;
    cmt_i[p].pdest           = pd;
    cmt_i[p].wdata           = data_of(pd);
  endtask

  task automatic log_out();
    if (rf_we_o) begin
      wlog.push_back(int'(rf_waddr_o));
      wdat.push_back(rf_wdata_o);
      wwv.push_back(wakeup_valid_o);
      wwp.push_back(wakeup_pdest_o);
      wcyc.push_back(cyc);
    end
  endtask

  task automatic clear_log();
    wlog.delete(); wdat.delete(); wwv.delete(); wwp.delete(); wcyc.delete();
    rdy0_low = 1'b0;
  endtask

  // Each pipe presents its queue head and holds it until it transfers.
  task automatic run_stream(input int max_cycles);
    int  n;
    bit  x0, x1;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cycles) begin
      if (q0.size() > 0) drive(0, 1'b1, 1'b1, q0[0]); else drive(0, 1'b0, 1'b0, 6'd0);
      if (q1.size() > 0) drive(1, 1'b1, 1'b1, q1[0]); else drive(1, 1'b0, 1'b0, 6'd0);
      x0 = cmt_i[0].base_info.valid && cmt_ready_o[0];
      x1 = cmt_i[1].base_info.valid && cmt_ready_o[1];
      if (q0.size() > 0 && !cmt_ready_o[0]) rdy0_low = 1'b1;
      tick();
      n++;
      if (x0) void'(q0.pop_front());
      if (x1) void'(q1.pop_front());
      log_out();
    end
    check("stream_done", (q0.size() == 0 && q1.size() == 0), 1);
    drive(0, 1'b0, 1'b0, 6'd0);
    drive(1, 1'b0, 1'b0, 6'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      log_out();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_rr [6];
    int s0 [$];
    int s1 [$];
    exp_rr = '{1, 11, 2, 12, 3, 13};
    drive(0, 1'b0, 1'b0, 6'd0);
    drive(1, 1'b0, 1'b0, 6'd0);

    // Reset state
    tick(); tick();
    check("rst_ready", cmt_ready_o, 2'b00);
    check("rst_we", rf_we_o, 0);
    check("rst_waddr", rf_waddr_o, 0);
    check("rst_wdata", rf_wdata_o, 0);
    check("rst_wv", wakeup_valid_o, 0);
    check("rst_wp", wakeup_pdest_o, 0);
    a_rst_n = 1'b1;
    tick(); tick(); tick();

    // Idle
    for (int k = 0; k < 10; k++) begin
      check("idle_ready", cmt_ready_o, 2'b11);
      check("idle_we", rf_we_o, 0);
      check("idle_wv", wakeup_valid_o, 0);
      tick();
    end

    // Single result, latency 2
    cmt_i[0].base_info.valid = 1'b1;
    cmt_i[0].we    = 1'b1;
    cmt_i[0].pdest = 6'd5;
    cmt_i[0].wdata = 32'hDEADBEEF;
    tick();
    drive(0, 1'b0, 1'b0, 6'd0);
    check("single_t1_we", rf_we_o, 0);
    tick();
    check("single_we", rf_we_o, 1);
    check("single_waddr", rf_waddr_o, 5);
    check("single_wdata", rf_wdata_o, 32'hDEADBEEF);
    check("single_wv", wakeup_valid_o, 1);
    check("single_wp", wakeup_pdest_o, 5);
    tick();
    check("single_t3_we", rf_we_o, 0);
    check("single_t3_wv", wakeup_valid_o, 0);
    check("single_hold_waddr", rf_waddr_o, 5);
    check("single_hold_wdata", rf_wdata_o, 32'hDEADBEEF);

    // we=0 entry consumes a slot; next entry follows one cycle later
    drive(1, 1'b1, 1'b0, 6'd7);
    tick();
    drive(1, 1'b1, 1'b1, 6'd8);
    tick();
    drive(1, 1'b0, 1'b0, 6'd0);
    check("we0_we", rf_we_o, 0);
    check("we0_wv", wakeup_valid_o, 0);
    check("we0_waddr", rf_waddr_o, 7);
    tick();
    check("we0_next_we", rf_we_o, 1);
    check("we0_next_waddr", rf_waddr_o, 8);
    check("we0_next_wdata", rf_wdata_o, 32'h1008);
    check("we0_next_wv", wakeup_valid_o, 1);
    check("we0_next_wp", wakeup_pdest_o, 8);
    tick();
    check("we0_after_we", rf_we_o, 0);

    // Round robin
    clear_log();
    q0 = '{6'd1, 6'd2, 6'd3};
    q1 = '{6'd11, 6'd12, 6'd13};
    run_stream(50);
    check("rr_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check("rr_order", wlog[k], exp_rr[k]);
        check("rr_wdata", wdat[k], data_of(6'(exp_rr[k])));
        check("rr_wv", wwv[k], 1);
        check("rr_wp", wwp[k], exp_rr[k]);
        check("rr_back_to_back", wcyc[k], wcyc[0] + k);
      end
    end

    // Backpressure
    clear_log();
    q0 = '{6'd20, 6'd21, 6'd22, 6'd23};
    q1 = '{6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35};
    run_stream(100);
    check("bp_ready0_dropped", rdy0_low, 1);
    check("bp_total", wlog.size(), 10);
    for (int k = 0; k < wlog.size(); k++) begin
      if (wlog[k] >= 20 && wlog[k] <= 23) s0.push_back(wlog[k]);
      else if (wlog[k] >= 30 && wlog[k] <= 35) s1.push_back(wlog[k]);
    end
    check("bp_p0_count", s0.size(), 4);
    check("bp_p1_count", s1.size(), 6);
    if (s0.size() == 4) for (int k = 0; k < 4; k++) check("bp_p0_order", s0[k], 20 + k);
    if (s1.size() == 6) for (int k = 0; k < 6; k++) check("bp_p1_order", s1[k], 30 + k);

    // Flush with a simultaneous transfer
    drive(0, 1'b1, 1'b1, 6'd40);
    drive(1, 1'b1, 1'b1, 6'd50);
    tick();
    drive(0, 1'b1, 1'b1, 6'd41);
    drive(1, 1'b1, 1'b1, 6'd51);
    tick();
    flush_i = 1'b1;
    drive(0, 1'b1, 1'b1, 6'd9);
    drive(1, 1'b0, 1'b0, 6'd0);
    tick();
    flush_i = 1'b0;
    drive(0, 1'b0, 1'b0, 6'd0);
    check("flush_ready", cmt_ready_o, 2'b11);
    check("flush_we", rf_we_o, 0);
    check("flush_wv", wakeup_valid_o, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_flush_we", rf_we_o, 0);
      check("post_flush_wv", wakeup_valid_o, 0);
    end

    // Reset asserted mid-operation
    drive(0, 1'b1, 1'b1, 6'd60);
    tick();
    drive(0, 1'b1, 1'b1, 6'd62);
    drive(1, 1'b1, 1'b1, 6'd61);
    tick();
    #2;
    a_rst_n = 1'b0;
    #1;
    drive(0, 1'b0, 1'b0, 6'd0);
    drive(1, 1'b0, 1'b0, 6'd0);
    check("midrst_we", rf_we_o, 0);
    check("midrst_ready", cmt_ready_o, 2'b00);
    check("midrst_waddr", rf_waddr_o, 0);
    check("midrst_wdata", rf_wdata_o, 0);
    check("midrst_wp", wakeup_pdest_o, 0);
    tick(); tick();
    a_rst_n = 1'b1;
    tick(); tick(); tick();
    check("midrst_ready_back", cmt_ready_o, 2'b11);
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_write", rf_we_o, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
